// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC register, fetches over imem req/ack, feeds decode via IF/ID.
// Latency: one instruction per cycle with zero-wait acks; IF/ID updates on the cycle after the ack.
// Backpressure: stall holds IF/ID (one-entry skid absorbs a landing word); flush drops held/in-flight data.
// Optional: FETCH_ALIGN_CHECK_EN forces word alignment of loaded PCs and raises sticky fetch_misalign.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        drop_q, drop_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        mis_q, mis_d;

  logic [31:0] npc_load;
  logic        npc_mis;
  logic        ack_v;
  logic        load_pc;

  // Value that would enter the PC register, and whether it was misaligned.
`ifdef FETCH_ALIGN_CHECK_EN
  assign npc_load = {next_pc[31:2], 2'b00};
  assign npc_mis  = |next_pc[1:0];
`else
  assign npc_load = next_pc;
  assign npc_mis  = 1'b0;
`endif

  // An ack only counts while a request is actually outstanding.
  assign ack_v = imem_ack & req_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath decisions; flush is applied last so it overrides capture and stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    vld_d        = vld_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    drop_d       = drop_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    mis_d        = mis_q;
    load_pc      = 1'b0;

    // Decode takes the held word whenever it is not stalled.
    if (vld_q && !stall) begin
      vld_d   = 1'b0;
      instr_d = NOP_INSTR;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      REQ: begin
        if (ack_v && !drop_q && !flush) begin
          load_pc = 1'b1;
          if (!stall || !vld_q) begin
            instr_d = imem_rdata;
            ifpc_d  = addr_q;
            vld_d   = 1'b1;
            addr_d  = npc_load;
          end else begin
            // IF/ID is occupied and stalled: park the word and pause fetching.
            skid_vld_d   = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = addr_q;
            req_d        = 1'b0;
            state_d      = HOLD;
          end
        end else if (ack_v && drop_q) begin
          // Stale response to a flushed request: discard and refetch at the redirect PC.
          drop_d = 1'b0;
          addr_d = pc_q;
        end
      end
      HOLD: begin
        if (!stall) begin
          vld_d      = skid_vld_q;
          instr_d    = skid_instr_q;
          ifpc_d     = skid_pc_q;
          skid_vld_d = 1'b0;
          state_d    = REQ;
          req_d      = 1'b1;
          addr_d     = pc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      vld_d      = 1'b0;
      instr_d    = NOP_INSTR;
      skid_vld_d = 1'b0;
      load_pc    = 1'b1;
      if (req_q && !ack_v) begin
        // Bus request cannot be withdrawn; keep it and discard its data later.
        drop_d = 1'b1;
      end else begin
        drop_d  = 1'b0;
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = npc_load;
      end
    end

    if (load_pc) begin
      pc_d  = npc_load;
      mis_d = mis_q | npc_mis;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= 32'h0;
      vld_q        <= 1'b0;
      instr_q      <= NOP_INSTR;
      ifpc_q       <= 32'h0;
      drop_q       <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      mis_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      vld_q        <= vld_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      drop_q       <= drop_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      mis_q        <= mis_d;
    end
  end

  assign pc_out         = pc_q;
  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign if_valid       = vld_q;
  assign if_instr       = instr_q;
  assign if_pc          = ifpc_q;
  assign fetch_misalign = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, ack latency, stall/skid, flush/drop, reset, alignment.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc_out(pc_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs for the coming edge; memory answers with the word at the current address.
  task automatic drive(input logic ack, input logic st, input logic fl, input logic [31:0] npc);
    imem_ack   = ack;
    stall      = st;
    flush      = fl;
    next_pc    = npc;
    imem_rdata = mem_word(imem_addr);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},    pc_out, 32'h0);
    check({tag, "_req"},   {31'b0, imem_req}, 32'h0);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_vld"},   {31'b0, if_valid}, 32'h0);
    check({tag, "_instr"}, if_instr, NOP);
    check({tag, "_ifpc"},  if_pc, 32'h0);
    check({tag, "_mis"},   {31'b0, fetch_misalign}, 32'h0);
  endtask

  // Reset, release, then n zero-wait fetches.
  task automatic boot(input int n);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    imem_addr_init();
    // Reset values.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check_reset("rst");

    // Zero-wait streaming.
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("first_vld", {31'b0, if_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
      tick();
      check("strm_addr", imem_addr, 32'(4 * (i + 1)));
      check("strm_ifpc", if_pc, 32'(4 * i));
      check("strm_instr", if_instr, mem_word(32'(4 * i)));
      check("strm_vld", {31'b0, if_valid}, 32'h1);
    end

    // Three wait cycles on the request to 0x8.
    boot(2);
    check("wait_addr0", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, pc_out + 32'd4);
      tick();
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h8);
      check("wait_pc", pc_out, 32'h8);
    end
    drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("wait_ifpc", if_pc, 32'h8);
    check("wait_vld", {31'b0, if_valid}, 32'h1);
    check("wait_next", imem_addr, 32'hC);
    drive(1'b0, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("wait_single", {31'b0, if_valid}, 32'h0);
    check("wait_nop", if_instr, NOP);

    // Stall while IF/ID holds 0x4 and 0x8 lands in the skid buffer.
    boot(2);
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 1'b1, 1'b0, pc_out + 32'd4);
      tick();
      check("stl_req", {31'b0, imem_req}, 32'h0);
      check("stl_ifpc", if_pc, 32'h4);
      check("stl_vld", {31'b0, if_valid}, 32'h1);
    end
    check("stl_pc", pc_out, 32'hC);
    drive(1'b0, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("unstl_ifpc", if_pc, 32'h8);
    check("unstl_instr", if_instr, mem_word(32'h8));
    check("unstl_req", {31'b0, imem_req}, 32'h1);
    check("unstl_addr", imem_addr, 32'hC);
    drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("unstl_ifpc2", if_pc, 32'hC);
    check("unstl_addr2", imem_addr, 32'h10);

    // Flush with request to 0x10 outstanding; its ack comes two cycles later.
    boot(4);
    check("fl_pre_addr", imem_addr, 32'h10);
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    check("fl_addr_hold", imem_addr, 32'h10);
    check("fl_req_hold", {31'b0, imem_req}, 32'h1);
    check("fl_vld", {31'b0, if_valid}, 32'h0);
    check("fl_pc", pc_out, 32'h100);
    drive(1'b0, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("fl_addr_hold2", imem_addr, 32'h10);
    drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("fl_drop_vld", {31'b0, if_valid}, 32'h0);
    check("fl_redir_addr", imem_addr, 32'h100);
    check("fl_redir_req", {31'b0, imem_req}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("fl_tgt_ifpc", if_pc, 32'h100);
    check("fl_tgt_instr", if_instr, mem_word(32'h100));
    check("fl_tgt_vld", {31'b0, if_valid}, 32'h1);
    // Flush coinciding with an ack.
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    check("flack_vld", {31'b0, if_valid}, 32'h0);
    check("flack_addr", imem_addr, 32'h200);
    check("flack_pc", pc_out, 32'h200);
    // Flush together with stall: flush wins.
    drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("flst_pre", if_pc, 32'h200);
    drive(1'b0, 1'b1, 1'b1, 32'h300);
    tick();
    check("flst_vld", {31'b0, if_valid}, 32'h0);
    check("flst_instr", if_instr, NOP);

    // Reset while a request is outstanding, ack during reset.
    boot(2);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check_reset("rstmid");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, pc_out + 32'd4);
    tick();
    check("rstmid_addr", imem_addr, 32'h0);
    check("rstmid_req", {31'b0, imem_req}, 32'h1);

    // Misaligned next_pc.
    boot(0);
    drive(1'b1, 1'b0, 1'b0, 32'h102);
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_pc", pc_out, 32'h100);
    check("mis_flag", {31'b0, fetch_misalign}, 32'h1);
`else
    check("mis_pc", pc_out, 32'h102);
    check("mis_flag", {31'b0, fetch_misalign}, 32'h0);
`endif
    drive(1'b1, 1'b0, 1'b0, 32'h108);
    tick();
    check("mis_pc2", pc_out, 32'h108);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_sticky", {31'b0, fetch_misalign}, 32'h1);
`else
    check("mis_sticky", {31'b0, fetch_misalign}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Inputs start from a defined value before the first edge.
  task automatic imem_addr_init();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    flush      = 1'b0;
    next_pc    = 32'h0;
  endtask

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the next-PC calculator.
- Holds the architectural PC register and drives it back to the calculator as currentPC.
- Latches the calculator's nextPC result into the PC register, fetches instructions from instruction memory over a req/ack handshake, and presents them to decode through an IF/ID register with stall and flush support.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, value driven on if_instr when no valid instruction is held.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- next_pc  input  32  next PC from the PC calculator; valid whenever pc_out is stable.
- pc_out  output  32  current PC register; feeds the calculator's currentPC.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  registered read address; stable while imem_req=1.
- imem_ack  input  1  memory response strobe; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- stall  input  1  decode cannot accept; hold IF/ID contents.
- flush  input  1  redirect (taken branch or jump); discard held and in-flight instructions.
- if_valid  output  1  IF/ID holds a valid instruction.
- if_instr  output  32  IF/ID instruction.
- if_pc  output  32  PC of if_instr.
- fetch_misalign  output  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc_out=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, fetch_misalign=0.
  - State=IDLE, drop flag=0, skid buffer empty.
  - Reset overrides every other input, including mid-request; an ack arriving during reset is ignored.
- FSM states: IDLE, REQ, HOLD.
- IDLE: next cycle goes to REQ with imem_req=1 and imem_addr=pc_out (registered).
  - First request appears exactly 1 cycle after reset release.
- REQ: imem_req stays 1 and imem_addr stays constant until imem_ack. Any ack latency (≥0 wait cycles) is accepted.
- Ack in REQ with drop=0, and (stall=0 or if_valid=0):
  - if_instr<=imem_rdata, if_pc<=imem_addr, if_valid<=1, pc_out<=next_pc.
  - Remain in REQ and issue the next request with imem_addr<=next_pc.
  - Back-to-back throughput is 1 instruction/cycle when ack is immediate.
- Ack in REQ with drop=0, stall=1, and if_valid=1:
  - Word and address go into the skid buffer; pc_out<=next_pc; imem_req<=0; go to HOLD.
- HOLD: imem_req=0 and the IF/ID register is unchanged while stall=1.
  - When stall=0: IF/ID<=skid buffer, buffer emptied, go to REQ issuing imem_addr<=pc_out.
- Decode consumption: if if_valid=1 and stall=0 with no new capture that cycle, if_valid<=0 and if_instr<=NOP_INSTR.
- Flush (priority over stall and over capture):
  - if_valid<=0, if_instr<=NOP_INSTR, skid emptied, pc_out<=next_pc (redirect target).
  - If a request is outstanding and not acked in the flush cycle: set drop=1. imem_req/imem_addr are held until ack, the returned data is discarded, drop is cleared, and a new request issues at pc_out the following cycle.
  - If the ack coincides with flush: data is discarded and the next request goes to the redirect target.
  - Flush in HOLD: go to REQ at the redirect target.
- Simultaneous flush and stall: flush wins and IF/ID is cleared.
- PC arithmetic is done upstream. This block does no adds; it only latches next_pc.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Whenever pc_out would load a next_pc with next_pc[1:0]!=0, the loaded value is {next_pc[31:2],2'b00}.
  - fetch_misalign is set to 1 and stays 1 until reset.
- Undefined: next_pc is loaded unmodified and fetch_misalign is tied 0.

Test Plan:
- Reset with RESET_PC=0, next_pc=pc_out+4, ack same cycle as req, stall=0 -> imem_addr 0,4,8,12 on consecutive cycles; if_pc follows one cycle later; if_instr matches memory.
- Ack delayed 3 cycles on the request to 0x8 -> imem_req and imem_addr=0x8 held for 4 cycles, pc_out unchanged until the ack, single capture of if_pc=0x8.
- stall=1 for 5 cycles while if_valid=1 (IF/ID holds 0x4) and the ack for 0x8 arrives -> IF/ID holds 0x4, imem_req=0 in HOLD; after stall drops, if_pc=0x8 then request 0xC. No loss or duplication.
- flush with next_pc=0x100 while the request to 0x10 is outstanding, ack 2 cycles later -> data for 0x10 never appears on if_valid; next imem_addr=0x100; if_valid stays 0 until the 0x100 word arrives.
- Reset asserted while REQ is outstanding, then ack during reset -> all outputs at reset values; after release the first imem_addr=RESET_PC.
- With FETCH_ALIGN_CHECK_EN defined, next_pc=0x102 -> pc_out=0x100 and fetch_misalign=1, sticky. Without the macro -> pc_out=0x102 and fetch_misalign=0.
